code_checker_param: RTL and testbench

- Parametrised keypad code buffer and comparator for the lock datapath.
- Captures a variable-length entered code one symbol per keypad strobe and holds a programmable stored code.
- On controller request, compares the two serially and emits a one-cycle match or mismatch pulse.
- Counts consecutive failures and enforces a timed lockout; sits between the keypad decoder and the lock controller FSM.

---
 rtl/code_checker_param.sv | 217 +++++++++++++++++++++
 tb/tb_code_checker_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_checker_param.sv
// -----------------------------------------------------------------------------
// code_checker_param
//
// Keypad code buffer and comparator for the lock datapath. Symbols strobed in
// from the keypad decoder are collected in an entry buffer. While prog_en is
// high the same buffer is used to build a new stored code, which prog_commit
// copies into the stored-code registers. On enter, the entry is compared
// against the stored code one symbol per cycle, and a one-cycle match or
// mismatch pulse is produced. Consecutive mismatches are counted; reaching
// MAX_TRIES puts the block into a timed lockout of LOCK_CYCLES cycles.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   key_valid    one-cycle strobe, key_sym valid
//   key_sym      keypad symbol (SYM_W bits)
//   enter        request to compare entry against stored code
//   clear        discard current entry
//   prog_en      level; enables programming of a new stored code
//   prog_commit  copy the entry buffer into the stored code
//   match        one-cycle pulse, code correct
//   mismatch     one-cycle pulse, code wrong
//   busy         high while comparing or locked out
//   locked       high while locked out
//   entry_count  symbols currently in the entry buffer
//   entry_full   entry buffer holds MAX_LEN symbols
//   stored_len   length of stored code, 0 = none programmed
//   fail_count   consecutive mismatches
// -----------------------------------------------------------------------------
module code_checker_param #(
    parameter int SYM_W       = 2,
    parameter int MAX_LEN     = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic [SYM_W-1:0]               key_sym,
    input  logic                           enter,
    input  logic                           clear,
    input  logic                           prog_en,
    input  logic                           prog_commit,
    output logic                           match,
    output logic                           mismatch,
    output logic                           busy,
    output logic                           locked,
    output logic [$clog2(MAX_LEN+1)-1:0]   entry_count,
    output logic                           entry_full,
    output logic [$clog2(MAX_LEN+1)-1:0]   stored_len,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESULT  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [CW-1:0]     stored_len_reg, stored_len_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [FW-1:0]     fail_reg, fail_next;
    logic [LW-1:0]     lock_cnt_reg, lock_cnt_next;
    logic              result_match_reg, result_match_next;

    logic [SYM_W-1:0]  entry_mem_reg  [MAX_LEN];
    logic [SYM_W-1:0]  stored_mem_reg [MAX_LEN];

    logic              entry_we;
    logic              commit;
    logic              full;
    logic [MAX_LEN-1:0] sym_eq;

    assign full = (count_reg == CW'(MAX_LEN));

    // Per-slot equality between entry and stored code; the serial compare
    // just selects the bit for the current index.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_eq
            assign sym_eq[gi] = (entry_mem_reg[gi] == stored_mem_reg[gi]);
        end
    endgenerate

    // State and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            count_reg        <= '0;
            stored_len_reg   <= '0;
            idx_reg          <= '0;
            fail_reg         <= '0;
            lock_cnt_reg     <= '0;
            result_match_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            stored_len_reg   <= stored_len_next;
            idx_reg          <= idx_next;
            fail_reg         <= fail_next;
            lock_cnt_reg     <= lock_cnt_next;
            result_match_reg <= result_match_next;
        end
    end

    // Entry buffer and stored code storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                entry_mem_reg[i]  <= '0;
                stored_mem_reg[i] <= '0;
            end
        end else begin
            if (entry_we) begin
                entry_mem_reg[count_reg[IW-1:0]] <= key_sym;
            end
            if (commit) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    stored_mem_reg[i] <= entry_mem_reg[i];
                end
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        stored_len_next   = stored_len_reg;
        idx_next          = idx_reg;
        fail_next         = fail_reg;
        lock_cnt_next     = lock_cnt_reg;
        result_match_next = result_match_reg;
        entry_we          = 1'b0;
        commit            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (clear) begin
                    count_next = '0;
                end else if (prog_en && prog_commit && (count_reg != '0)) begin
                    commit          = 1'b1;
                    stored_len_next = count_reg;
                    count_next      = '0;
                end else if (enter && !prog_en) begin
                    state_next = S_COMPARE;
                    idx_next   = '0;
                end else if (key_valid && !full) begin
                    // An ignored commit or enter falls through to key capture.
                    entry_we   = 1'b1;
                    count_next = count_reg + CW'(1);
                end
            end

            S_COMPARE: begin
                if ((count_reg != stored_len_reg) || (stored_len_reg == '0)) begin
                    state_next        = S_RESULT;
                    result_match_next = 1'b0;
                end else if (!sym_eq[idx_reg]) begin
                    state_next        = S_RESULT;
                    result_match_next = 1'b0;
                end else if (CW'(idx_reg) == (stored_len_reg - CW'(1))) begin
                    state_next        = S_RESULT;
                    result_match_next = 1'b1;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end

            S_RESULT: begin
                count_next = '0;
                if (result_match_reg) begin
                    fail_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    fail_next = fail_reg + FW'(1);
                    if ((fail_reg + FW'(1)) == FW'(MAX_TRIES)) begin
                        state_next    = S_LOCKOUT;
                        lock_cnt_next = LW'(LOCK_CYCLES - 1);
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_LOCKOUT: begin
                // Loaded with LOCK_CYCLES-1, so exactly LOCK_CYCLES cycles here.
                if (lock_cnt_reg == '0) begin
                    fail_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg - LW'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign match       = (state_reg == S_RESULT) && result_match_reg;
    assign mismatch    = (state_reg == S_RESULT) && !result_match_reg;
    assign busy        = (state_reg == S_COMPARE) || (state_reg == S_LOCKOUT);
    assign locked      = (state_reg == S_LOCKOUT);
    assign entry_count = count_reg;
    assign entry_full  = full;
    assign stored_len  = stored_len_reg;
    assign fail_count  = fail_reg;

endmodule

// File: tb/tb_code_checker_param.sv
// -----------------------------------------------------------------------------
// tb_code_checker_param
//
// Self-checking bench for code_checker_param with default parameters
// (SYM_W=2, MAX_LEN=8, MAX_TRIES=3, LOCK_CYCLES=1000). A vector table covers
// single-cycle entry-buffer behaviour; hand-written sequences cover compare
// latency, fail counting, lockout and reset aborts.
// -----------------------------------------------------------------------------
module tb_code_checker_param;

    localparam int LOCK_CYCLES = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [1:0] key_sym;
    logic       enter;
    logic       clear;
    logic       prog_en;
    logic       prog_commit;
    logic       match;
    logic       mismatch;
    logic       busy;
    logic       locked;
    logic [3:0] entry_count;
    logic       entry_full;
    logic [3:0] stored_len;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_checker_param #(
        .SYM_W(2), .MAX_LEN(8), .MAX_TRIES(3), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_sym(key_sym),
        .enter(enter), .clear(clear), .prog_en(prog_en), .prog_commit(prog_commit),
        .match(match), .mismatch(mismatch), .busy(busy), .locked(locked),
        .entry_count(entry_count), .entry_full(entry_full),
        .stored_len(stored_len), .fail_count(fail_count)
    );

    typedef struct {
        logic       kv;
        logic [1:0] sym;
        logic       clr;
        logic       pen;
        logic       pcommit;
        int         exp_count;
        int         exp_full;
        int         exp_slen;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key_valid = 0; key_sym = 0; enter = 0; clear = 0;
        prog_en = 0; prog_commit = 0;
    endtask

    task automatic key(input logic [1:0] s);
        key_valid = 1; key_sym = s;
        step();
        key_valid = 0;
    endtask

    task automatic key_code(input logic [15:0] code, input int n);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < n; i++) key(c[2*i +: 2]);
    endtask

    // Pulse enter and wait for the result pulse; lat = edges from enter to pulse.
    task automatic do_enter(output int lat, output int got_match, output int got_mm);
        enter = 1;
        step();
        enter = 0;
        lat = 1;
        while (!match && !mismatch && lat < 40) begin
            step();
            lat++;
        end
        got_match = int'(match);
        got_mm    = int'(mismatch);
        if (!match && !mismatch) begin
            check("result_timeout", 0, 1);
        end
    endtask

    task automatic try_code(input string name, input logic [15:0] code, input int n,
                            input int exp_lat, input int exp_match, input int exp_fail);
        int lat, m, mm;
        key_code(code, n);
        do_enter(lat, m, mm);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_match"}, m, exp_match);
        check({name, "_mismatch"}, mm, 1 - exp_match);
        step();
        check({name, "_fail_count"}, int'(fail_count), exp_fail);
        check({name, "_entry_count"}, int'(entry_count), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_match"}, int'(match), 0);
        check({name, "_mismatch"}, int'(mismatch), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_locked"}, int'(locked), 0);
        check({name, "_entry_count"}, int'(entry_count), 0);
        check({name, "_entry_full"}, int'(entry_full), 0);
        check({name, "_stored_len"}, int'(stored_len), 0);
        check({name, "_fail_count"}, int'(fail_count), 0);
    endtask

    task automatic pulse_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        int lat, m, mm, n;

        // kv sym clr pen pcommit | count full stored_len
        vecs[0]  = '{1, 2'd1, 0, 1, 0, 1, 0, 0};
        vecs[1]  = '{1, 2'd2, 0, 1, 0, 2, 0, 0};
        vecs[2]  = '{1, 2'd3, 0, 1, 0, 3, 0, 0};
        vecs[3]  = '{1, 2'd0, 0, 1, 0, 4, 0, 0};
        vecs[4]  = '{0, 2'd0, 0, 1, 1, 0, 0, 4};
        vecs[5]  = '{0, 2'd0, 0, 1, 1, 0, 0, 4};   // empty commit ignored
        vecs[6]  = '{1, 2'd3, 0, 0, 0, 1, 0, 4};
        vecs[7]  = '{1, 2'd3, 0, 0, 0, 2, 0, 4};
        vecs[8]  = '{1, 2'd3, 0, 0, 0, 3, 0, 4};
        vecs[9]  = '{1, 2'd3, 0, 0, 0, 4, 0, 4};
        vecs[10] = '{1, 2'd3, 0, 0, 0, 5, 0, 4};
        vecs[11] = '{1, 2'd3, 0, 0, 0, 6, 0, 4};
        vecs[12] = '{1, 2'd3, 0, 0, 0, 7, 0, 4};
        vecs[13] = '{1, 2'd3, 0, 0, 0, 8, 1, 4};
        vecs[14] = '{1, 2'd1, 0, 0, 0, 8, 1, 4};   // 9th symbol dropped
        vecs[15] = '{1, 2'd1, 1, 0, 0, 0, 0, 4};   // clear beats key_valid
        vecs[16] = '{1, 2'd2, 0, 0, 0, 1, 0, 4};
        vecs[17] = '{0, 2'd0, 1, 0, 0, 0, 0, 4};

        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        check_reset_state("reset");

        for (int i = 0; i < 18; i++) begin
            key_valid = vecs[i].kv; key_sym = vecs[i].sym; clear = vecs[i].clr;
            prog_en = vecs[i].pen; prog_commit = vecs[i].pcommit;
            step();
            idle_inputs();
            $display("vec %0d: count=%0d full=%0d stored_len=%0d", i,
                     entry_count, entry_full, stored_len);
            check($sformatf("vec%0d_count", i), int'(entry_count), vecs[i].exp_count);
            check($sformatf("vec%0d_full", i), int'(entry_full), vecs[i].exp_full);
            check($sformatf("vec%0d_stored_len", i), int'(stored_len), vecs[i].exp_slen);
            check($sformatf("vec%0d_pulse", i), int'(match | mismatch), 0);
        end

        // Stored code 1,2,3,0 (symbols packed LSB first).
        try_code("match_ok", 16'h0039, 4, 5, 1, 0);
        try_code("wrong_idx2", 16'h0029, 4, 4, 0, 1);
        try_code("short", 16'h0039, 3, 2, 0, 2);
        try_code("match_clears", 16'h0039, 4, 5, 1, 0);

        // enter while prog_en high is ignored
        key_code(16'h0039, 4);
        prog_en = 1; enter = 1;
        step();
        enter = 0;
        step();
        prog_en = 0;
        check("prog_en_enter_busy", int'(busy), 0);
        check("prog_en_enter_count", int'(entry_count), 4);
        clear = 1;
        step();
        clear = 0;

        // Three consecutive failures lead to lockout.
        try_code("lk1", 16'h0029, 4, 4, 0, 1);
        try_code("lk2", 16'h0039, 3, 2, 0, 2);
        key_code(16'h0029, 4);
        do_enter(lat, m, mm);
        check("lk3_mismatch", mm, 1);
        step();
        check("lock_locked", int'(locked), 1);
        check("lock_busy", int'(busy), 1);
        check("lock_fail_count", int'(fail_count), 3);
        n = 0;
        while (locked && n < 2000) begin
            n++;
            key_valid = (n < 6);
            key_sym   = 2'd1;
            enter     = (n == 3) || (n == 8);
            clear     = (n == 10);
            step();
        end
        idle_inputs();
        $display("lockout cycles=%0d", n);
        check("lock_cycles", n, LOCK_CYCLES);
        check("post_lock_fail_count", int'(fail_count), 0);
        check("post_lock_entry_count", int'(entry_count), 0);
        check("post_lock_busy", int'(busy), 0);
        try_code("post_lock_match", 16'h0039, 4, 5, 1, 0);

        // Reset during COMPARE
        key_code(16'h0039, 4);
        enter = 1;
        step();
        enter = 0;
        check("mid_compare_busy", int'(busy), 1);
        pulse_reset();
        check_reset_state("rst_compare");

        // No stored code: every entry mismatches.
        try_code("nocode_one", 16'h0001, 1, 2, 0, 1);
        try_code("nocode_empty", 16'h0000, 0, 2, 0, 2);
        key_code(16'h0039, 4);
        do_enter(lat, m, mm);
        check("nocode_third_mismatch", mm, 1);
        step();
        check("nocode_locked", int'(locked), 1);
        repeat (5) step();

        // Reset during LOCKOUT
        pulse_reset();
        check_reset_state("rst_lockout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
